// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and multiply FSM state type
package cpu_pkg;

    localparam int WIDTH = 32;

    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] OP_MADDU    = 6'd28;
    localparam logic [5:0] FUNCT_MADDU = 6'd1;
    localparam logic [5:0] FUNCT_MFHI  = 6'd16;
    localparam logic [5:0] FUNCT_MFLO  = 6'd18;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mult_state_t;

endpackage

// File: rtl/mult_shift_add_core.sv
// rtl/mult_shift_add_core.sv - shift-add datapath: operand shifters, accumulator, step counter
module mult_shift_add_core #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic [2*WIDTH-1:0] product_next,
    output logic               last_iter
);

    localparam int CW = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(ITER - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] product;
    logic [CW-1:0]      count;

    // The final step's sum is handed straight to the HI/LO write, so expose it combinationally.
    always_comb begin
        product_next = mplier[0] ? (product + mcand) : product;
        last_iter    = (count == LAST_COUNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            count   <= '0;
        end else if (load) begin
            mcand   <= {{WIDTH{1'b0}}, src_a};
            mplier  <= src_b;
            product <= '0;
            count   <= '0;
        end else if (step) begin
            product <= product_next;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            count   <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_multu_hilo.sv
// rtl/seq_multu_hilo.sv - iterative unsigned MULTU/MADDU unit owning the HI/LO register pair
module seq_multu_hilo #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_madd,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import cpu_pkg::*;

    mult_state_t        state;
    mult_state_t        state_next;
    logic               load;
    logic               step;
    logic               last_iter;
    logic               madd_q;
    logic               finish;
    logic [2*WIDTH-1:0] product_next;
    logic [2*WIDTH-1:0] hilo_new;

    mult_shift_add_core #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) u_core (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .step         (step),
        .src_a        (src_a),
        .src_b        (src_b),
        .product_next (product_next),
        .last_iter    (last_iter)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_iter) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // MADDU carry out of the top bit is dropped by the 2*WIDTH-wide sum.
    always_comb begin
        finish   = (state == RUN) && last_iter;
        hilo_new = madd_q ? ({hi, lo} + product_next) : product_next;
        busy     = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            madd_q <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                madd_q <= op_madd;
            end
            if (finish) begin
                {hi, lo} <= hilo_new;
            end
        end
    end

endmodule

// File: tb/tb_seq_multu_hilo.sv
// tb/tb_seq_multu_hilo.sv - scoreboard bench for seq_multu_hilo against an arithmetic HI:LO model
module tb_seq_multu_hilo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op_madd = 1'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [63:0] hilo;
        int          issue_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model_hilo = '0;
    int          cycle = 0;
    int          checks = 0;
    int          errors = 0;
    logic        reset_q = 1'b1;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    seq_multu_hilo dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op_madd (op_madd),
        .src_a   (src_a),
        .src_b   (src_b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle   <= cycle + 1;
        reset_q <= reset;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse and guards HI/LO stability.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_q) begin
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("hilo", {hi, lo}, e.hilo);
                    chk("latency", 64'(cycle - e.issue_cyc), 64'd33);
                    chk("busy_in_done", {63'd0, busy}, 64'd0);
                end
            end else begin
                chk("hilo_stable", {hi, lo}, {prev_hi, prev_lo});
            end
        end
        prev_hi = hi;
        prev_lo = lo;
    end

    // Called at a negedge; returns at the following negedge with start dropped.
    task automatic issue(input logic madd, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        start   = 1'b1;
        op_madd = madd;
        src_a   = a;
        src_b   = b;
        if (madd) model_hilo = model_hilo + (64'(a) * 64'(b));
        else      model_hilo = 64'(a) * 64'(b);
        e.hilo      = model_hilo;
        e.issue_cyc = cycle;
        sb.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        src_a   = $urandom;
        src_b   = $urandom;
        op_madd = 1'($urandom);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_hi",   {32'd0, hi}, 64'd0);
        chk("reset_lo",   {32'd0, lo}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(1'b0, 32'd3, 32'd5);                wait_done();
        @(negedge clk);
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);  wait_done();
        @(negedge clk);
        issue(1'b0, 32'd3, 32'd5);                wait_done();
        @(negedge clk);
        issue(1'b1, 32'd2, 32'd3);                wait_done();
        @(negedge clk);
        issue(1'b1, 32'd0, 32'd7);                wait_done();
        @(negedge clk);
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);  wait_done();
        @(negedge clk);
        issue(1'b1, 32'd2, 32'hFFFFFFFF);         wait_done();
        @(negedge clk);
        chk("preload_max", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
        issue(1'b1, 32'd1, 32'd1);                wait_done();
        chk("madd_wrap", {hi, lo}, 64'd0);
        @(negedge clk);

        // Start pulses at RUN edges 5, 31 and 32 must be ignored
        issue(1'b0, 32'd1234, 32'd5678);
        for (int j = 2; j <= 32; j++) begin
            @(negedge clk);
            start = (j == 5 || j == 31 || j == 32);
            src_a = $urandom;
            src_b = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_after_ignored_starts", {63'd0, done}, 64'd1);
        @(negedge clk);
        chk("idle_after_ignored", {63'd0, busy}, 64'd0);

        // Back-to-back: a start in the done cycle is accepted
        issue(1'b0, 32'd77, 32'd91);   wait_done();
        issue(1'b1, 32'd13, 32'd17);   wait_done();
        issue(1'b0, 32'd0, 32'hABCD);  wait_done();
        @(negedge clk);

        // Randomized ops with random gaps
        for (int k = 0; k < 24; k++) begin
            issue(1'($urandom), $urandom, $urandom);
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);

        // Reset at RUN cycle 10 aborts with no write and no done
        issue(1'b1, 32'hDEADBEEF, 32'h12345678);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        sb.delete();
        model_hilo = '0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", {63'd0, busy}, 64'd0);

        issue(1'b1, 32'd6, 32'd7);  wait_done();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
